// File: rtl/funrv32_pkg.sv
// Shared definitions for the RV32 integer register file slice.
package funrv32_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam logic [REG_ADDR_W-1:0] CLR_FIRST = 5'd1;
  localparam logic [REG_ADDR_W-1:0] CLR_LAST  = 5'd31;

endpackage

// File: rtl/rv32_rf_clr_seq.sv
// Post-reset zero-fill sequencer: walks x1..x31 once, then parks in RUN.
module rv32_rf_clr_seq
  import funrv32_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetb,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] clr_addr,
  output logic                  clr_we
);

  localparam rf_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  rf_state_e             state_r;
  rf_state_e             state_nxt_s;
  logic [REG_ADDR_W-1:0] clr_cnt_r;
  logic [REG_ADDR_W-1:0] clr_cnt_nxt_s;

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r   <= RESET_STATE;
      clr_cnt_r <= CLR_FIRST;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next-state: the counter holds at the last address instead of wrapping.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == CLR_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + 5'd1;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s   = RESET_STATE;
        clr_cnt_nxt_s = CLR_FIRST;
      end
    endcase
  end

  assign busy     = (state_r == ST_CLEAR);
  assign clr_addr = clr_cnt_r;
  assign clr_we   = (state_r == ST_CLEAR);

endmodule

// File: rtl/rv32_regfile_2r1w.sv
// RV32 integer register file: two registered read ports, one write port,
// write-first forwarding, and an optional zero-fill sweep after reset.
module rv32_regfile_2r1w
  import funrv32_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] ad,
  input  logic [XLEN-1:0]       rd,
  input  logic [REG_ADDR_W-1:0] a1,
  input  logic [REG_ADDR_W-1:0] a2,
  output logic [XLEN-1:0]       r1,
  output logic [XLEN-1:0]       r2,
  output logic                  ready
);

  // x0 is hard-wired to zero, so storage starts at x1.
  logic [XLEN-1:0] mem_r [1:NUM_REGS-1];

  logic                  clr_busy_s;
  logic [REG_ADDR_W-1:0] clr_addr_s;
  logic                  clr_we_s;

  logic                  wr_en_s;
  logic [REG_ADDR_W-1:0] wr_addr_s;
  logic [XLEN-1:0]       wr_data_s;
  logic [XLEN-1:0]       r1_nxt_s;
  logic [XLEN-1:0]       r2_nxt_s;
  logic                  ready_nxt_s;
  logic [XLEN-1:0]       r1_r;
  logic [XLEN-1:0]       r2_r;
  logic                  ready_r;

  rv32_rf_clr_seq #(
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr_seq (
    .clk     (clk),
    .resetb  (resetb),
    .busy    (clr_busy_s),
    .clr_addr(clr_addr_s),
    .clr_we  (clr_we_s)
  );

  // Storage write-port mux; the sweep owns the port while busy.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = clr_addr_s;
    wr_data_s = {XLEN{1'b0}};
    if (clr_busy_s) begin
      wr_en_s   = clr_we_s;
      wr_addr_s = clr_addr_s;
      wr_data_s = {XLEN{1'b0}};
    end else begin
      wr_en_s   = we && (ad != 5'd0);
      wr_addr_s = ad;
      wr_data_s = rd;
    end
  end

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s && (wr_addr_s != 5'd0)) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Read-data selection with write-first forwarding.
  always_comb begin
    r1_nxt_s = {XLEN{1'b0}};
    r2_nxt_s = {XLEN{1'b0}};
    if (clr_busy_s) begin
      r1_nxt_s = {XLEN{1'b0}};
      r2_nxt_s = {XLEN{1'b0}};
    end else begin
      if (a1 == 5'd0) begin
        r1_nxt_s = {XLEN{1'b0}};
      end else if (we && (ad == a1)) begin
        r1_nxt_s = rd;
      end else begin
        r1_nxt_s = mem_r[a1];
      end
      if (a2 == 5'd0) begin
        r2_nxt_s = {XLEN{1'b0}};
      end else if (we && (ad == a2)) begin
        r2_nxt_s = rd;
      end else begin
        r2_nxt_s = mem_r[a2];
      end
    end
  end

  // ready rises together with the FSM entering RUN.
  assign ready_nxt_s = !clr_busy_s || (clr_addr_s == CLR_LAST);

  // Registered read data and ready.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r1_r    <= {XLEN{1'b0}};
      r2_r    <= {XLEN{1'b0}};
      ready_r <= 1'b0;
    end else begin
      r1_r    <= r1_nxt_s;
      r2_r    <= r2_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  assign r1    = r1_r;
  assign r2    = r2_r;
  assign ready = ready_r;

endmodule
